// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between NUM_REQ
// requesters, with a built-in zero-fill clear engine and fixed 2-cycle read latency.
module sram_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CLEAR_DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  input  logic                             clear_start,
  output logic                             clear_busy,
  output logic                             clear_done,
  output logic                             mem_sram_CEN,
  output logic                             mem_sram_GWEN,
  output logic [ADDR_WIDTH-1:0]            mem_sram_A,
  output logic [DATA_WIDTH-1:0]            mem_sram_D,
  input  logic [DATA_WIDTH-1:0]            mem_sram_Q
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(CLEAR_DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       rr_nxt;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       cand;
  logic                   grant_any;
  logic                   hs;
  logic [ADDR_WIDTH:0]    clr_cnt;
  logic                   clr_last;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_we;
  logic [NUM_REQ-1:0]     rd_tag;
  logic [NUM_REQ-1:0]     rsp_tag;

  // First valid requester scanning from rr_ptr upward, modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign rr_nxt   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign sel_addr = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_we   = req_we[grant_idx];
  assign clr_last = (clr_cnt == CLR_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clear_start) state_nxt = CLEAR;
      CLEAR:   if (clr_last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: clear_start pre-empts any grant in the same cycle.
  always_comb begin
    req_ready  = '0;
    hs         = 1'b0;
    clear_busy = (state == CLEAR);
    if (state == IDLE && !clear_start && grant_any) begin
      hs                   = 1'b1;
      req_ready[grant_idx] = 1'b1;
    end
  end

  // SRAM command registers, round-robin pointer and clear counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_sram_CEN  <= 1'b1;
      mem_sram_GWEN <= 1'b1;
      mem_sram_A    <= '0;
      mem_sram_D    <= '0;
      rr_ptr        <= '0;
      clr_cnt       <= '0;
      clear_done    <= 1'b0;
    end else begin
      mem_sram_CEN  <= 1'b1;
      mem_sram_GWEN <= 1'b1;
      clear_done    <= 1'b0;
      if (state == CLEAR) begin
        mem_sram_CEN  <= 1'b0;
        mem_sram_GWEN <= 1'b0;
        mem_sram_A    <= clr_cnt[ADDR_WIDTH-1:0];
        mem_sram_D    <= '0;
        if (clr_last) begin
          clr_cnt    <= '0;
          clear_done <= 1'b1;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
      end else if (hs) begin
        mem_sram_CEN  <= 1'b0;
        mem_sram_GWEN <= ~sel_we;
        mem_sram_A    <= sel_addr;
        mem_sram_D    <= sel_data;
        rr_ptr        <= rr_nxt;
      end
    end
  end

  // Two-stage response tag: issue cycle, then SRAM output cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag  <= '0;
      rsp_tag <= '0;
    end else begin
      rd_tag  <= '0;
      rsp_tag <= rd_tag;
      if (hs && !sel_we) begin
        rd_tag[grant_idx] <= 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_tag;
  assign rsp_rdata = mem_sram_Q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: cycle model of grants/pins/clear plus
// a response queue checked against the fixed-latency read path.
module tb_sram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 4;
  localparam int unsigned CD = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic              mem_sram_CEN;
  logic              mem_sram_GWEN;
  logic [AW-1:0]     mem_sram_A;
  logic [DW-1:0]     mem_sram_D;
  logic [DW-1:0]     mem_sram_Q;

  sram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .CLEAR_DEPTH(CD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .mem_sram_CEN (mem_sram_CEN),
    .mem_sram_GWEN(mem_sram_GWEN),
    .mem_sram_A   (mem_sram_A),
    .mem_sram_D   (mem_sram_D),
    .mem_sram_Q   (mem_sram_Q)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int unsigned a);
    return {32'hC0DE_0000 | a, 32'h5A5A_0000 + a};
  endfunction

  // Registered-read single-port SRAM
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!mem_sram_CEN) begin
      if (!mem_sram_GWEN) sram[mem_sram_A] <= mem_sram_D;
      else                mem_sram_Q <= sram[mem_sram_A];
    end
  end

  typedef struct {
    int unsigned   id;
    logic [DW-1:0] data;
    int unsigned   due;
  } rsp_t;

  rsp_t          sb[$];
  int unsigned   grant_log[$];
  int unsigned   cyc = 0;
  int unsigned   zero_wr = 0;
  int unsigned   done_cnt = 0;
  logic [DW-1:0] last_rsp = '0;

  // Model state
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  int unsigned   m_cnt = 0;
  int unsigned   m_rr = 0;
  logic          e_cen = 1'b1;
  logic          e_gwen = 1'b1;
  logic [AW-1:0] e_a = '0;
  logic [DW-1:0] e_d = '0;
  logic [NR-1:0] er;
  logic [NR-1:0] er_rsp;
  int unsigned   gi;
  bit            found;
  bit            nd;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_rr = 0;
      e_cen = 1'b1; e_gwen = 1'b1; e_a = '0; e_d = '0;
      sb.delete();
    end
    er = '0; gi = 0; found = 1'b0;
    if (!m_busy && !clear_start) begin
      for (int k = 0; k < NR; k++) begin
        if (!found && req_valid[(m_rr + k) % NR]) begin
          found = 1'b1;
          gi = (m_rr + k) % NR;
        end
      end
    end
    if (found) er[gi] = 1'b1;
    check_eq("req_ready", req_ready, er);
    check_eq("cen", mem_sram_CEN, e_cen);
    check_eq("gwen", mem_sram_GWEN, e_gwen);
    check_eq("addr", mem_sram_A, e_a);
    check_eq("wdata", mem_sram_D, e_d);
    check_eq("clear_busy", clear_busy, m_busy);
    check_eq("clear_done", clear_done, m_done);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      er_rsp = '0;
      er_rsp[sb[0].id] = 1'b1;
      check_eq("rsp_valid", rsp_valid, er_rsp);
      check_eq("rsp_rdata", rsp_rdata, sb[0].data);
      void'(sb.pop_front());
    end else begin
      check_eq("rsp_idle", rsp_valid, '0);
    end

    for (int k = 0; k < NR; k++) if (req_ready[k]) grant_log.push_back(k);
    if (!mem_sram_CEN && !mem_sram_GWEN && mem_sram_D == '0 && mem_sram_A < CD) zero_wr++;
    if (clear_done) done_cnt++;
    if (rsp_valid != '0) last_rsp = rsp_rdata;

    if (rst_n) begin
      nd = 1'b0;
      if (m_busy) begin
        e_cen = 1'b0; e_gwen = 1'b0; e_a = AW'(m_cnt); e_d = '0;
        m_mem[m_cnt] = '0;
        if (m_cnt == CD - 1) begin
          m_busy = 1'b0; m_cnt = 0; nd = 1'b1;
        end else begin
          m_cnt++;
        end
      end else if (clear_start) begin
        m_busy = 1'b1; e_cen = 1'b1; e_gwen = 1'b1;
      end else if (found) begin
        e_cen = 1'b0;
        e_gwen = ~req_we[gi];
        e_a = req_addr[gi*AW +: AW];
        e_d = req_wdata[gi*DW +: DW];
        m_rr = (gi + 1) % NR;
        if (req_we[gi]) m_mem[e_a] = e_d;
        else sb.push_back('{gi, m_mem[e_a], cyc + 2});
      end else begin
        e_cen = 1'b1; e_gwen = 1'b1;
      end
      m_done = nd;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req_valid = '0;
    clear_start = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = pattern(i);
      m_mem[i] = pattern(i);
    end
    mem_sram_Q = '0;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
    do_reset();

    // Write then read through requester 2
    drive(2, 1'b1, 8'd5, 64'hDEAD_BEEF);
    step();
    req_valid = '0;
    check_eq("t1_w_cen", mem_sram_CEN, 1'b0);
    check_eq("t1_w_gwen", mem_sram_GWEN, 1'b0);
    check_eq("t1_w_addr", mem_sram_A, 8'd5);
    check_eq("t1_w_data", mem_sram_D, 64'hDEAD_BEEF);
    drive(2, 1'b0, 8'd5, '0);
    step();
    req_valid = '0;
    step();
    check_eq("t1_rsp_valid", rsp_valid, 4'b0100);
    check_eq("t1_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF);

    // All four reading continuously
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NR; i++) drive(i, 1'b0, AW'(10 + i), '0);
    repeat (8) step();
    req_valid = '0;
    repeat (3) step();
    check_eq("t2_grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) check_eq("t2_grant_order", grant_log[i], i % NR);

    // Requesters 1 and 3 with rr_ptr at 2
    do_reset();
    drive(1, 1'b0, 8'd3, '0);
    step();
    req_valid = '0;
    grant_log.delete();
    drive(1, 1'b0, 8'd4, '0);
    drive(3, 1'b0, 8'd6, '0);
    step();
    step();
    req_valid = '0;
    step();
    check_eq("t3_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check_eq("t3_first", grant_log[0], 3);
      check_eq("t3_second", grant_log[1], 1);
    end

    // Clear pre-empts a pending request, then the request reads zero
    drive(0, 1'b1, 8'd7, 64'h55);
    step();
    req_valid = '0;
    step();
    zero_wr = 0; done_cnt = 0; last_rsp = '1;
    drive(0, 1'b0, 8'd7, '0);
    clear_start = 1'b1;
    #1;
    check_eq("t4_ready_blocked", req_ready, '0);
    step();
    clear_start = 1'b0;
    k = 0;
    while (!req_ready[0] && k < 40) begin
      step();
      k++;
    end
    check_eq("t4_grant_after_clear", req_ready, 4'b0001);
    step();
    req_valid = '0;
    repeat (3) step();
    check_eq("t4_zero_writes", zero_wr, CD);
    check_eq("t4_done_pulses", done_cnt, 1);
    check_eq("t4_read_after_clear", last_rsp, '0);

    // Read in flight while clear starts
    drive(1, 1'b0, 8'd40, '0);
    step();
    req_valid = '0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check_eq("t5_rsp_valid", rsp_valid, 4'b0010);
    check_eq("t5_rsp_rdata", rsp_rdata, pattern(40));
    k = 0;
    while (clear_busy && k < 40) begin
      step();
      k++;
    end
    check_eq("t5_clear_end", clear_busy, 1'b0);
    repeat (2) step();

    // Reset midway through a clear
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_cen", mem_sram_CEN, 1'b1);
    check_eq("t6_gwen", mem_sram_GWEN, 1'b1);
    check_eq("t6_addr", mem_sram_A, '0);
    check_eq("t6_data", mem_sram_D, '0);
    check_eq("t6_busy", clear_busy, 1'b0);
    check_eq("t6_done", clear_done, 1'b0);
    check_eq("t6_rsp", rsp_valid, '0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check_eq("t6_busy_after", clear_busy, 1'b0);

    // Reset drops an in-flight read; the port still works afterwards
    drive(2, 1'b0, 8'd40, '0);
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check_eq("t6b_rsp", rsp_valid, '0);
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    drive(3, 1'b0, 8'd40, '0);
    step();
    req_valid = '0;
    step();
    check_eq("t6b_rsp_valid", rsp_valid, 4'b1000);
    check_eq("t6b_rsp_rdata", rsp_rdata, pattern(40));
    repeat (3) step();
    check_eq("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port synchronous SRAM macro (registered read, active-low CEN/GWEN) between NUM_REQ requesters.
- Each requester uses a valid/ready request channel and gets a fixed-latency read response.
- A built-in clear engine zero-fills the SRAM on command, which replaces the costly per-word reset clear in the macro itself.
- Sits between the octree traversal/update units and the SRAM instance.

Parameters:
- ADDR_WIDTH, 15, SRAM word-address width.
- DATA_WIDTH, 64, SRAM word width.
- NUM_REQ, 4, number of requesters (2..8).
- CLEAR_DEPTH, 1<<ADDR_WIDTH, number of words written by the clear engine, starting at address 0.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  flattened write data.
- rsp_valid  output  NUM_REQ  one-hot read-response strobe.
- rsp_rdata  output  DATA_WIDTH  read data, valid when any rsp_valid bit is set.
- clear_start  input  1  pulse; starts a zero-fill.
- clear_busy  output  1  high while the clear engine owns the SRAM.
- clear_done  output  1  one-cycle pulse after the last clear write is issued.
- mem_sram_CEN  output  1  SRAM chip enable, active low, registered.
- mem_sram_GWEN  output  1  SRAM write enable, active low, registered.
- mem_sram_A  output  ADDR_WIDTH  SRAM address, registered.
- mem_sram_D  output  DATA_WIDTH  SRAM write data, registered, always driven.
- mem_sram_Q  input  DATA_WIDTH  SRAM read data; updates at the edge after a CEN-low read cycle.

Behaviour:
- Reset values:
  - mem_sram_CEN=1, mem_sram_GWEN=1, mem_sram_A=0, mem_sram_D=0.
  - rsp_valid=0, clear_busy=0, clear_done=0, req_ready=0.
  - rr_ptr=0, clear counter=0, state=IDLE, response pipeline empty.
  - Reset mid-operation aborts any clear and drops in-flight reads; no rsp_valid afterwards.
- FSM states are IDLE and CLEAR.
- IDLE arbitration:
  - req_ready is combinational from req_valid, rr_ptr, state and clear_start.
  - Grant goes to the first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - A handshake is req_valid[i] & req_ready[i] at a rising edge.
  - On a handshake to i: rr_ptr <= (i+1) mod NUM_REQ; next cycle CEN=0, GWEN=~req_we[i], A/D = slice i.
  - With no handshake: CEN=1, GWEN=1; A and D hold their previous values.
  - Throughput is one access per cycle, back-to-back, no bubbles.
- Read latency:
  - A handshake at edge T puts the command on the pins during T..T+1. The SRAM samples it at T+1.
  - At T+1 a registered response tag is set, so rsp_valid[i]=1 during T+1..T+2 with rsp_rdata = mem_sram_Q (combinational pass-through).
  - Fixed 2-cycle latency; responses return in issue order.
  - There is no response backpressure; the requester must accept.
  - Writes produce no response.
- Clear:
  - clear_start high in IDLE at an edge moves the FSM to CLEAR.
  - clear_start wins over any pending request that cycle, so req_ready=0 while clear_start is high.
  - In CLEAR: req_ready=0 and clear_busy=1. Each cycle issues a write of all-zero data to counter address 0,1,...,CLEAR_DEPTH-1.
  - Reads issued before entering CLEAR still complete normally.
  - After the write to CLEAR_DEPTH-1 is issued: clear_done=1 for one cycle, clear_busy=0, state returns to IDLE, counter resets to 0.
  - Requests may be granted in that same first IDLE cycle.
  - clear_start during CLEAR is ignored.
  - The counter is ADDR_WIDTH+1 bits wide, so CLEAR_DEPTH=2^ADDR_WIDTH terminates without wrap.
- Invariants:
  - At most one req_ready bit is set.
  - req_ready[i] implies req_valid[i].
  - rr_ptr changes only on a handshake.

Test Plan:
- Reset, then requester 2 writes 0xDEAD_BEEF to addr 5 and then reads addr 5. Required: CEN=0/GWEN=0/A=5 the cycle after the write handshake; rsp_valid=4'b0100 with rsp_rdata=0xDEAD_BEEF two cycles after the read handshake.
- All 4 requesters hold reads valid continuously for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; responses arrive in the same order, one per cycle, each 2 cycles after its grant.
- Requesters 1 and 3 valid with rr_ptr=2. Required: 3 is granted first, then 1; requester 3 sees no second grant while 1 is waiting.
- CLEAR_DEPTH=16: write 0x55 to addr 7, pulse clear_start with requester 0 valid in the same cycle. Required: req_ready=0; 16 consecutive zero writes to addrs 0..15; clear_done pulses once; a read of addr 7 then returns 0.
- Read issued at edge T, clear_start at T+1. Required: that read's rsp_valid still fires at T+2 with the correct data.
- Assert rst_n=0 midway through a clear. Required: outputs return to reset values immediately; after release, clear_busy=0 and no stray rsp_valid.
